// File: rtl/mips_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pkg
//  Description : Shared types and constants for the multicycle MIPS core.
//                Provides the PC sequencer state type, the reset vector
//                and the sequential fetch increment.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_cpu_pkg;

    typedef enum logic {
        PC_IDLE    = 1'b0,
        PC_PENDING = 1'b1
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC00000;
    localparam int          PC_STEP         = 4;

endpackage : mips_cpu_pkg
`default_nettype wire

// File: rtl/mips_cpu_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : mips_cpu_pc_seq
//  Description : Program-counter sequencer for the multicycle MIPS core.
//                Steps the fetch PC on every instruction advance, applies
//                branch/jump redirects after DELAY_SLOTS delay slots and
//                freezes completely while waitrequest is high.
//  Ports       : clk, reset (sync, active-high)
//                waitrequest     - memory stall, holds all state
//                advance         - current instruction completes
//                redirect_valid  - branch taken / jump (sampled with advance)
//                redirect_target - branch/jump destination
//                pc              - current fetch PC
//                pc_plus_step    - pc + STEP (link address)
//                delay_pending   - redirect waiting behind delay slots
//                addr_err        - misaligned fetch PC
//                exc_valid, exc_vector - exception request (PC_EXC_EN only)
//  Config      : define PC_EXC_EN to add the exception redirect path.
//  Revision    : 1.0  initial release
// ============================================================================
module mips_cpu_pc_seq
    import mips_cpu_pkg::*;
#(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
    parameter int                STEP         = PC_STEP,
    parameter int                DELAY_SLOTS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              waitrequest,
    input  logic              advance,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
`ifdef PC_EXC_EN
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_vector,
`endif
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus_step,
    output logic              delay_pending,
    output logic              addr_err
);

    // Counter preload when entering PENDING: the branch's own advance already
    // consumed the first delay slot.
    localparam logic [2:0] C_CNT_INIT = (DELAY_SLOTS > 0) ? 3'(DELAY_SLOTS - 1) : 3'd0;
    localparam logic [ADDR_W-1:0] C_STEP = ADDR_W'(STEP);

    pc_state_t         r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_target;

    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [2:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] w_target_nxt;
    logic [ADDR_W-1:0] w_pc_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= PC_IDLE;
            r_pc     <= RESET_VECTOR;
            r_cnt    <= 3'd0;
            r_target <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_target <= w_target_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; everything holds unless the memory is ready and
    // either an exception or an advance is presented.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_pc_inc     = r_pc + C_STEP;

        if (!waitrequest) begin
`ifdef PC_EXC_EN
            // Exceptions win over any redirect, including one already pending.
            if (exc_valid) begin
                w_pc_nxt    = exc_vector;
                w_state_nxt = PC_IDLE;
                w_cnt_nxt   = 3'd0;
            end else
`endif
            if (advance) begin
                case (r_state)
                    PC_IDLE: begin
                        if (redirect_valid && (DELAY_SLOTS == 0)) begin
                            w_pc_nxt = redirect_target;
                        end else if (redirect_valid) begin
                            w_pc_nxt     = w_pc_inc;
                            w_target_nxt = redirect_target;
                            w_cnt_nxt    = C_CNT_INIT;
                            w_state_nxt  = PC_PENDING;
                        end else begin
                            w_pc_nxt = w_pc_inc;
                        end
                    end
                    PC_PENDING: begin
                        // A branch sitting in a delay slot is ignored: the
                        // first target already captured wins.
                        if (r_cnt == 3'd0) begin
                            w_pc_nxt    = r_target;
                            w_state_nxt = PC_IDLE;
                        end else begin
                            w_pc_nxt  = w_pc_inc;
                            w_cnt_nxt = r_cnt - 3'd1;
                        end
                    end
                    default: begin
                        w_state_nxt = PC_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs; reset forces the visible PC to the vector immediately,
    // before the reset edge has been taken.
    // ------------------------------------------------------------------
    assign pc            = reset ? RESET_VECTOR : r_pc;
    assign pc_plus_step  = pc + C_STEP;
    assign delay_pending = !reset && (r_state == PC_PENDING);
    assign addr_err      = (pc[1:0] != 2'b00);

endmodule : mips_cpu_pc_seq
`default_nettype wire

// File: tb/tb_mips_cpu_pc_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_cpu_pc_seq
//  Description : Self-checking bench for mips_cpu_pc_seq. Two instances are
//                driven in lockstep, one with DELAY_SLOTS=1 and one with
//                DELAY_SLOTS=3, and compared against a reference model that
//                counts remaining advances until a redirect lands.
//                Honours PC_EXC_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_cpu_pc_seq;

    localparam logic [31:0] RV = 32'hBFC00000;

    logic        clk = 1'b0;
    logic        reset, waitrequest, advance, redirect_valid;
    logic [31:0] redirect_target;
`ifdef PC_EXC_EN
    logic        exc_valid;
    logic [31:0] exc_vector;
`endif
    logic [31:0] pc_a, pps_a, pc_b, pps_b;
    logic        dp_a, ae_a, dp_b, ae_b;

    int total = 0;
    int bad   = 0;

    // Reference model: rem = advances still to go before the target lands.
    logic [31:0] m_pc  [2];
    logic [31:0] m_tgt [2];
    int          m_rem [2];

    always #5 clk = ~clk;

    mips_cpu_pc_seq #(.ADDR_W(32), .RESET_VECTOR(RV), .STEP(4), .DELAY_SLOTS(1)) u_d1 (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .advance(advance),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
`ifdef PC_EXC_EN
        .exc_valid(exc_valid), .exc_vector(exc_vector),
`endif
        .pc(pc_a), .pc_plus_step(pps_a), .delay_pending(dp_a), .addr_err(ae_a)
    );

    mips_cpu_pc_seq #(.ADDR_W(32), .RESET_VECTOR(RV), .STEP(4), .DELAY_SLOTS(3)) u_d3 (
        .clk(clk), .reset(reset), .waitrequest(waitrequest), .advance(advance),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
`ifdef PC_EXC_EN
        .exc_valid(exc_valid), .exc_vector(exc_vector),
`endif
        .pc(pc_b), .pc_plus_step(pps_b), .delay_pending(dp_b), .addr_err(ae_b)
    );

    function automatic int dly(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic idle_inputs();
        reset = 1'b0; waitrequest = 1'b0; advance = 1'b0;
        redirect_valid = 1'b0; redirect_target = '0;
`ifdef PC_EXC_EN
        exc_valid = 1'b0; exc_vector = '0;
`endif
    endtask

    // One clock edge: the model absorbs the inputs present at the edge,
    // then outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_pc[k] = RV; m_rem[k] = 0; m_tgt[k] = '0;
            end else if (!waitrequest) begin
`ifdef PC_EXC_EN
                if (exc_valid) begin
                    m_pc[k] = exc_vector; m_rem[k] = 0;
                end else
`endif
                if (advance) begin
                    if (m_rem[k] > 0) begin
                        m_rem[k] = m_rem[k] - 1;
                        m_pc[k]  = (m_rem[k] == 0) ? m_tgt[k] : m_pc[k] + 32'd4;
                    end else if (redirect_valid) begin
                        if (dly(k) == 0) m_pc[k] = redirect_target;
                        else begin
                            m_rem[k] = dly(k); m_tgt[k] = redirect_target;
                            m_pc[k]  = m_pc[k] + 32'd4;
                        end
                    end else begin
                        m_pc[k] = m_pc[k] + 32'd4;
                    end
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic adv(input logic rv, input logic [31:0] tgt);
        advance = 1'b1; redirect_valid = rv; redirect_target = tgt;
        tick();
        advance = 1'b0; redirect_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        total++; if (pc_a !== RV) begin bad++; $display("FAIL reset_comb: pc=%h want %h", pc_a, RV); end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (pc_a !== RV || pc_b !== RV) begin bad++; $display("FAIL reset_pc: pc=%h/%h want %h", pc_a, pc_b, RV); end
            total++; if (dp_a !== 1'b0 || ae_a !== 1'b0) begin bad++; $display("FAIL reset_flags: dp=%b ae=%b want 0 0", dp_a, ae_a); end
        end
        reset = 1'b0;
        tick();
        total++; if (pc_a !== RV) begin bad++; $display("FAIL reset_after: pc=%h want %h", pc_a, RV); end
    endtask

    task automatic test_step();
        for (int i = 1; i <= 3; i++) begin
            adv(1'b0, '0);
            total++; if (pc_a !== RV + 32'(4*i)) begin bad++; $display("FAIL step_%0d: pc=%h want %h", i, pc_a, RV + 32'(4*i)); end
            total++; if (pps_a !== RV + 32'(4*i+4)) begin bad++; $display("FAIL step_pps_%0d: got %h want %h", i, pps_a, RV + 32'(4*i+4)); end
        end
    endtask

    task automatic test_branch(input int stall);
        do_reset();
        for (int i = 0; i < 4; i++) adv(1'b0, '0);
        total++; if (pc_a !== 32'hBFC00010) begin bad++; $display("FAIL br_start: pc=%h want BFC00010", pc_a); end
        adv(1'b1, 32'hBFC00100);
        total++; if (pc_a !== 32'hBFC00014 || dp_a !== 1'b1) begin bad++; $display("FAIL br_slot: pc=%h dp=%b want BFC00014 1", pc_a, dp_a); end
        for (int i = 0; i < stall; i++) begin
            waitrequest = 1'b1; advance = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h1234_5678;
            tick();
            total++; if (pc_a !== 32'hBFC00014 || dp_a !== 1'b1 || pc_b !== m_pc[1]) begin
                bad++; $display("FAIL stall_hold_%0d: pc=%h dp=%b pc3=%h want BFC00014 1 %h", i, pc_a, dp_a, pc_b, m_pc[1]);
            end
        end
        idle_inputs();
        adv(1'b0, '0);
        total++; if (pc_a !== 32'hBFC00100 || dp_a !== 1'b0) begin bad++; $display("FAIL br_land: pc=%h dp=%b want BFC00100 0", pc_a, dp_a); end
        total++; if (pc_b !== m_pc[1]) begin bad++; $display("FAIL br_d3: pc=%h want %h", pc_b, m_pc[1]); end
    endtask

    task automatic test_delay_branch();
        do_reset();
        adv(1'b1, 32'hBFC00200);
        adv(1'b1, 32'hBFC00400);
        total++; if (pc_a !== 32'hBFC00200 || pc_b !== 32'hBFC00008) begin bad++; $display("FAIL dsb_1: pc=%h/%h want BFC00200/BFC00008", pc_a, pc_b); end
        adv(1'b0, '0);
        total++; if (pc_a !== 32'hBFC00204 || pc_b !== 32'hBFC0000C || dp_b !== 1'b1) begin bad++; $display("FAIL dsb_2: pc=%h/%h dp3=%b want BFC00204/BFC0000C 1", pc_a, pc_b, dp_b); end
        adv(1'b0, '0);
        total++; if (pc_b !== 32'hBFC00200 || dp_b !== 1'b0) begin bad++; $display("FAIL dsb_d3_land: pc=%h dp=%b want BFC00200 0", pc_b, dp_b); end
        adv(1'b0, '0);
        total++; if (pc_a !== 32'hBFC0020C || pc_b !== 32'hBFC00204) begin bad++; $display("FAIL dsb_noB: pc=%h/%h want BFC0020C/BFC00204", pc_a, pc_b); end
    endtask

    task automatic test_wrap_misalign();
        do_reset();
        adv(1'b1, 32'hFFFFFFFC);
        adv(1'b0, '0);
        total++; if (pc_a !== 32'hFFFFFFFC || pps_a !== 32'h0) begin bad++; $display("FAIL wrap_pre: pc=%h pps=%h want FFFFFFFC 0", pc_a, pps_a); end
        adv(1'b0, '0);
        total++; if (pc_a !== 32'h0) begin bad++; $display("FAIL wrap: pc=%h want 00000000", pc_a); end
        adv(1'b1, 32'hBFC00102);
        total++; if (ae_a !== 1'b0) begin bad++; $display("FAIL misalign_pre: ae=%b want 0", ae_a); end
        adv(1'b0, '0);
        total++; if (pc_a !== 32'hBFC00102 || ae_a !== 1'b1 || pps_a !== 32'hBFC00106) begin
            bad++; $display("FAIL misalign: pc=%h ae=%b pps=%h want BFC00102 1 BFC00106", pc_a, ae_a, pps_a);
        end
        total++; if (pc_b !== m_pc[1] || ae_b !== (m_pc[1][1:0] != 2'b00)) begin bad++; $display("FAIL misalign_d3: pc=%h want %h", pc_b, m_pc[1]); end
    endtask

    task automatic test_reset_mid_delay();
        do_reset();
        adv(1'b1, 32'hBFC00300);
        reset = 1'b1;
        #1;
        total++; if (pc_b !== RV || dp_b !== 1'b0) begin bad++; $display("FAIL rst_mid_comb: pc=%h dp=%b want %h 0", pc_b, dp_b, RV); end
        waitrequest = 1'b1; advance = 1'b1;
        tick();
        idle_inputs();
        tick();
        total++; if (pc_b !== RV || dp_b !== 1'b0 || pc_a !== RV) begin bad++; $display("FAIL rst_mid: pc=%h dp=%b want %h 0", pc_b, dp_b, RV); end
        for (int i = 0; i < 4; i++) adv(1'b0, '0);
        total++; if (pc_b !== RV + 32'd16) begin bad++; $display("FAIL rst_mid_cancel: pc=%h want %h", pc_b, RV + 32'd16); end
    endtask

`ifdef PC_EXC_EN
    task automatic test_exc();
        do_reset();
        adv(1'b1, 32'hBFC00500);
        exc_valid = 1'b1; exc_vector = 32'hBFC00380;
        adv(1'b1, 32'hBFC00600);
        exc_valid = 1'b0;
        total++; if (pc_a !== 32'hBFC00380 || pc_b !== 32'hBFC00380 || dp_b !== 1'b0) begin
            bad++; $display("FAIL exc_load: pc=%h/%h dp=%b want BFC00380 0", pc_a, pc_b, dp_b);
        end
        for (int i = 0; i < 4; i++) adv(1'b0, '0);
        total++; if (pc_b !== 32'hBFC00390 || pc_a !== 32'hBFC00390) begin bad++; $display("FAIL exc_drop: pc=%h/%h want BFC00390", pc_a, pc_b); end
    endtask
`endif

    task automatic test_random();
        logic [31:0] epc, opc, opps;
        logic        odp, oae;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            reset           = ($urandom_range(0, 49) == 0);
            waitrequest     = ($urandom_range(0, 9) < 3);
            advance         = ($urandom_range(0, 9) < 6);
            redirect_valid  = ($urandom_range(0, 3) == 0);
            redirect_target = ($urandom_range(0, 7) == 0) ? 32'($urandom) : {32'($urandom) & 32'hFFFF_FFFC};
`ifdef PC_EXC_EN
            exc_valid  = ($urandom_range(0, 29) == 0);
            exc_vector = 32'($urandom) & 32'hFFFF_FFFC;
`endif
            tick();
            for (int k = 0; k < 2; k++) begin
                opc  = (k == 0) ? pc_a  : pc_b;
                opps = (k == 0) ? pps_a : pps_b;
                odp  = (k == 0) ? dp_a  : dp_b;
                oae  = (k == 0) ? ae_a  : ae_b;
                epc  = reset ? RV : m_pc[k];
                total++;
                if (opc !== epc || opps !== epc + 32'd4 || odp !== (!reset && m_rem[k] > 0) || oae !== (epc[1:0] != 2'b00)) begin
                    bad++;
                    $display("FAIL rand_%0d_d%0d: pc=%h pps=%h dp=%b ae=%b want %h %h %b %b", n, dly(k),
                             opc, opps, odp, oae, epc, epc + 32'd4, (!reset && m_rem[k] > 0), (epc[1:0] != 2'b00));
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin m_pc[k] = RV; m_rem[k] = 0; m_tgt[k] = '0; end
        test_reset();
        test_step();
        test_branch(0);
        test_branch(5);
        test_delay_branch();
        test_wrap_misalign();
        test_reset_mid_delay();
`ifdef PC_EXC_EN
        test_exc();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mips_cpu_pc_seq
`default_nettype wire
